counter_mod: RTL
================

COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter Width, default 6, counter and bound width in bits (2..32).
REQ-002 Parameter Wrap, default 1, boundary mode: 1 = wrap-around, 0 = saturate.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 opc_i  input  3  operation select, sampled every clk_i rising edge.
REQ-006 max_i  input  Width  inclusive upper bound of count range [0, max_i].
REQ-007 load_i  input  Width  value written on LOAD.
REQ-008 cnt_o  output  Width  current count, direct register output.
REQ-009 tc_o  output  1  terminal count, high while cnt_o == max_i; combinational from cnt_o and max_i only.
REQ-010 zero_o  output  1  high while cnt_o == 0; combinational from cnt_o only.
REQ-011 evt_o  output  1  registered one-cycle pulse, high the cycle after a boundary event (wrap or saturation hit).
REQ-012 ovf_o  output  1  registered sticky flag, set by any boundary event, cleared only by CLRF, CLR or reset.

Function
REQ-013 opc_i 000 CLR: cnt_o <= 0, ovf_o <= 0, no event.
REQ-014 opc_i 001 HOLD: cnt_o unchanged.
REQ-015 opc_i 010 UP: cnt_o <= cnt_o + 1 when cnt_o < max_i.
REQ-016 opc_i 011 DOWN: cnt_o <= cnt_o - 1 when cnt_o > 0.
REQ-017 opc_i 100 LOAD: cnt_o <= min(load_i, max_i), no event.
REQ-018 opc_i 101 CLRF: ovf_o <= 0, cnt_o unchanged.
REQ-019 opc_i 110, 111: identical to HOLD.
REQ-020 UP with cnt_o >= max_i is a boundary event: Wrap=1 -> cnt_o <= 0; Wrap=0 -> cnt_o <= max_i.
REQ-021 DOWN with cnt_o == 0 is a boundary event: Wrap=1 -> cnt_o <= max_i; Wrap=0 -> cnt_o stays 0.
REQ-022 cnt_o > max_i (max_i lowered at run time) with DOWN: cnt_o <= max_i, no event.
REQ-023 Boundary event: evt_o high exactly one cycle after the triggering edge; ovf_o set on the same edge.
REQ-024 Saturate mode: every UP/DOWN issued at the boundary is a new event, so repeated attempts give evt_o high every cycle.
REQ-025 max_i == 0: UP and DOWN are both boundary events every cycle; cnt_o stays 0.
REQ-026 Arithmetic is Width bits, unsigned; no carry bit is exposed; comparisons are unsigned.
REQ-027 Latency: one clock from opc_i sample to cnt_o, evt_o and ovf_o update; tc_o and zero_o follow cnt_o with no added cycle.

Reset
REQ-028 rst_i high forces cnt_o = 0, evt_o = 0 and ovf_o = 0 immediately, independent of clk_i.
REQ-029 After reset: tc_o = (max_i == 0) and zero_o = 1.
REQ-030 Reset asserted mid-operation discards any pending event; no evt_o pulse follows reset release.
REQ-031 First operation is taken on the first rising edge with rst_i low.

Structure
REQ-032 Opcode encodings (CLR, HOLD, UP, DOWN, LOAD, CLRF) are localparams in a shared header (counter_pkg), also used by controlling FSMs.
REQ-033 Single module; no sub-module.
REQ-034 Next-state mux is one combinational block; all registers (count, event, sticky) are in one asynchronous-reset sequential block.

Verification
REQ-035 Width=6, Wrap=1, max_i=9: CLR, then 10 x UP -> cnt_o 1..9 then 0; evt_o high exactly once, one cycle after the 9->0 edge; ovf_o=1.
REQ-036 Wrap=1, max_i=9, cnt=0: DOWN -> cnt_o=9, evt_o pulse, tc_o=1; CLRF -> ovf_o=0, cnt_o stays 9.
REQ-037 Wrap=0, max_i=5: 8 x UP from 0 -> cnt_o stops at 5; evt_o high on the last 3 cycles; ovf_o=1; then DOWN -> 4, evt_o=0.
REQ-038 max_i=20: LOAD load_i=63 -> cnt_o=20, tc_o=1, no evt_o; then set max_i=10 and issue DOWN -> cnt_o=10, no event.
REQ-039 Count to 7 with UP; assert rst_i between clock edges -> cnt_o=0, ovf_o=0 at once; after release, HOLD keeps cnt_o=0 and evt_o stays 0.
REQ-040 max_i=0: alternate UP/DOWN for 4 cycles -> cnt_o=0, tc_o=1, zero_o=1, evt_o high every cycle; opc_i 110/111 -> cnt_o held.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared opcode encodings for counter_mod and any FSM that drives it.
// Codes 110 and 111 are spare and behave as HOLD.
package counter_pkg;

  localparam logic [2:0] OPC_CLR  = 3'b000;
  localparam logic [2:0] OPC_HOLD = 3'b001;
  localparam logic [2:0] OPC_UP   = 3'b010;
  localparam logic [2:0] OPC_DOWN = 3'b011;
  localparam logic [2:0] OPC_LOAD = 3'b100;
  localparam logic [2:0] OPC_CLRF = 3'b101;

endpackage

// File: rtl/counter_mod.sv
// Bounded up/down counter over [0, max_i] with wrap or saturate mode.
// Boundary hits give a one-cycle evt_o pulse and set the sticky ovf_o.
module counter_mod
  import counter_pkg::*;
#(
  parameter int Width = 6,
  parameter bit Wrap  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       opc_i,
  input  logic [Width-1:0] max_i,
  input  logic [Width-1:0] load_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o,
  output logic             zero_o,
  output logic             evt_o,
  output logic             ovf_o
);

  localparam logic [Width-1:0] One  = 1;
  localparam logic [Width-1:0] Zero = '0;

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;
  logic             evt_q;
  logic             evt_d;
  logic             ovf_q;
  logic             ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    evt_d = 1'b0;
    ovf_d = ovf_q;
    unique case (opc_i)
      OPC_CLR: begin
        cnt_d = Zero;
        ovf_d = 1'b0;
      end
      OPC_UP: begin
        if (cnt_q < max_i) begin
          cnt_d = cnt_q + One;
        end else begin
          evt_d = 1'b1;
          cnt_d = Wrap ? Zero : max_i;
        end
      end
      OPC_DOWN: begin
        // A count left above a lowered bound is pulled back quietly.
        if (cnt_q > max_i) begin
          cnt_d = max_i;
        end else if (cnt_q == Zero) begin
          evt_d = 1'b1;
          cnt_d = Wrap ? max_i : Zero;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      OPC_LOAD: begin
        cnt_d = (load_i < max_i) ? load_i : max_i;
      end
      OPC_CLRF: begin
        ovf_d = 1'b0;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    if (evt_d) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= Zero;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign evt_o  = evt_q;
  assign ovf_o  = ovf_q;
  assign tc_o   = (cnt_q == max_i);
  assign zero_o = (cnt_q == Zero);

endmodule
